mips_load_store_unit: RTL and testbench
=======================================

// Module: mips_load_store_unit
// PURPOSE
//  Sits between the core's memory stage and the data memory; sole driver of the memory's
//  MemWrite/MemRead/Adress/WriteData; consumes its ReadData (registered, valid the cycle after MemRead).
//  Accepts byte/half/word load/store requests on a valid/ready handshake.
//  Handles loads with sign/zero extension. Sub-word stores are done as read-modify-write (word memory).
//  Returns one response per request on a valid/ready handshake.
// PARAMETERS
//  MemSize   4096  memory depth in 32-bit words; power of 2; word index wraps modulo MemSize
// PORTS
//  Clk          in   1   clock, all state on posedge
//  Rst_n        in   1   asynchronous active-low reset
//  ReqValid     in   1   request present
//  ReqReady     out  1   request accepted when ReqValid & ReqReady
//  ReqWrite     in   1   1=store, 0=load
//  ReqSize      in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  ReqUnsigned  in   1   loads: 1=zero-extend, 0=sign-extend; ignored for stores
//  ReqAddr      in   32  byte address
//  ReqWData     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  RespValid    out  1   response present; held until RespValid & RespReady
//  RespReady    in   1   response consumed
//  RespData     out  32  extended load data; 0 for stores
//  RespError    out  1   misaligned request (only with LSU_MISALIGN_TRAP_EN)
//  MemWrite     out  1   to data memory
//  MemRead      out  1   to data memory
//  Adress       out  32  word index = ReqAddr[31:2] & (MemSize-1), zero-extended
//  WriteData    out  32  to data memory
//  ReadData     in   32  from data memory
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all outputs 0 except ReqReady=0.
//  - ReqReady=1 only in IDLE (registered). One request in flight, no pipelining.
//  - Little-endian lanes: byte k = bits [8k+7:8k], k=ReqAddr[1:0]; half h = bits [16h+15:16h], h=ReqAddr[1].
//  - FSM: IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, RESP. Cycle 0 = acceptance edge.
//    - Load: IDLE->RD_ISSUE (MemRead=1, cycle 1)->RD_DATA (ReadData valid; extract and extend)->RESP.
//      RespValid first high in cycle 3.
//    - Store word: IDLE->WR_ISSUE (MemWrite=1, WriteData=ReqWData, cycle 1)->RESP.
//      RespValid first high in cycle 2.
//    - Store byte/half: IDLE->RD_ISSUE->RD_DATA (merge lane into ReadData)->WR_ISSUE (cycle 3)->RESP.
//      RespValid first high in cycle 4, after the write edge.
//    - RESP: hold RespValid/RespData/RespError stable until RespReady; then ->IDLE. ReqReady=1 next cycle.
//  - MemRead and MemWrite are never high together. Each is high for exactly one cycle per access.
//  - Adress/WriteData are held stable from issue through the end of the access.
//  - Word index at MemSize-1 + 1 wraps to 0. No out-of-range error.
//  - Reset mid-operation: the async clear drops MemWrite/MemRead immediately; no write occurs at the
//    following edge; the pending response is discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - Half with ReqAddr[0]=1, or word with ReqAddr[1:0]!=0, is misaligned.
//    - Misaligned requests: no memory access; IDLE->RESP with RespError=1, RespData=0.
//    - RespValid first high in cycle 1.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - Offending low address bits are ignored (half uses ReqAddr[1]; word uses ReqAddr[31:2]).
//    - RespError is tied 0.
// STRUCTURE
//  - mips_lsu_pkg: state enum (lsu_state_t), size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), lane-select helpers.
//  - Sub-module mips_lsu_lane_fmt (combinational):
//    - extract+extend(ReadData, offset, size, unsigned);
//    - merge(ReadData, ReqWData, offset, size).
// TESTING
//  - SW 0xDEADBEEF @0x10; LW @0x10 -> MemWrite only in cycle 1, Adress=4;
//    load RespData=0xDEADBEEF, RespValid in cycle 3.
//  - After above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE;
//    LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
//  - SB 0x55 @0x11 over 0xDEADBEEF -> read then write; word becomes 0xDEAD55EF; RespValid in cycle 4.
//  - Addr 0x4000 with MemSize=4096 -> Adress=0 (wrap);
//    RespReady held low 5 cycles -> RespValid/RespData stable, ReqReady=0 throughout.
//  - TRAP_EN: LW @0x2 -> RespError=1, RespData=0 in cycle 1, no MemRead/MemWrite.
//    Without TRAP_EN: LW @0x2 reads word 0.
//  - Rst_n low during WR_ISSUE of SH 0x1234 @0x20 -> MemWrite drops immediately;
//    word 8 unchanged; ReqReady=1 after reset release.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_t  - controller states
//   lsu_size_t   - access size encoding (SZ_BYTE/SZ_HALF/SZ_WORD, 11 reserved = word)
//   byteLane / halfLane / laneMask / isMisaligned - little-endian lane helpers
`timescale 1ns/1ps
package mips_lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_DATA,
      WR_ISSUE,
      RESP
   } lsu_state_t;

   typedef logic [1:0] lsu_size_t;

   localparam lsu_size_t SZ_BYTE = 2'b00;
   localparam lsu_size_t SZ_HALF = 2'b01;
   localparam lsu_size_t SZ_WORD = 2'b10;

   // Both 10 and the reserved 11 encoding behave as a full word.
   function automatic logic isWordSize(input lsu_size_t size);
      return size[1];
   endfunction

   // Lane shift in bits: byte k at 8k, half h at 16h, word at 0.
   function automatic logic [4:0] laneShift(input lsu_size_t size, input logic [1:0] offset);
      if (isWordSize(size))    return 5'd0;
      else if (size == SZ_HALF) return {offset[1], 4'b0000};
      else                      return {offset, 3'b000};
   endfunction

   function automatic logic [31:0] laneMask(input lsu_size_t size, input logic [1:0] offset);
      if (isWordSize(size))    return '1;
      else if (size == SZ_HALF) return 32'h0000_FFFF << laneShift(size, offset);
      else                      return 32'h0000_00FF << laneShift(size, offset);
   endfunction

   function automatic logic [7:0] byteLane(input logic [31:0] word, input logic [1:0] k);
      logic [31:0] sh;
      sh = word >> {k, 3'b000};
      return sh[7:0];
   endfunction

   function automatic logic [15:0] halfLane(input logic [31:0] word, input logic h);
      logic [31:0] sh;
      sh = word >> {h, 4'b0000};
      return sh[15:0];
   endfunction

   function automatic logic isMisaligned(input lsu_size_t size, input logic [1:0] offset);
      if (isWordSize(size))    return offset != 2'b00;
      else if (size == SZ_HALF) return offset[0];
      else                      return 1'b0;
   endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// mips_load_store_unit_if: request/response handshake between the memory stage
// (master) and the load/store unit (slave).
//   Req*  : valid/ready request channel (write, size, unsigned, byte address, store data)
//   Resp* : valid/ready response channel (extended load data, misalignment error)
`timescale 1ns/1ps
interface mips_load_store_unit_if;
   import mips_lsu_pkg::*;

   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   lsu_size_t   ReqSize;
   logic        ReqUnsigned;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic        RespValid;
   logic        RespReady;
   logic [31:0] RespData;
   logic        RespError;

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, RespReady,
      input  ReqReady, RespValid, RespData, RespError
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, RespReady,
      output ReqReady, RespValid, RespData, RespError
   );

endinterface

// File: rtl/mips_lsu_lane_fmt.sv
// mips_lsu_lane_fmt: combinational lane formatting for the load/store unit.
//   ReadData  in  word read from memory
//   WData     in  right-justified store data
//   Offset    in  byte address bits [1:0]
//   Size      in  access size
//   Unsigned  in  1 = zero-extend loads
//   LoadData  out selected lane, sign/zero extended
//   MergeData out ReadData with the store lane replaced (WData for words)
`timescale 1ns/1ps
module mips_lsu_lane_fmt
   import mips_lsu_pkg::*;
(
   input  logic [31:0] ReadData,
   input  logic [31:0] WData,
   input  logic [1:0]  Offset,
   input  lsu_size_t   Size,
   input  logic        Unsigned,
   output logic [31:0] LoadData,
   output logic [31:0] MergeData
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic [31:0] mask;

   always_comb begin
      byteVal = byteLane(ReadData, Offset);
      halfVal = halfLane(ReadData, Offset[1]);
      mask    = laneMask(Size, Offset);

      if (isWordSize(Size))
         LoadData = ReadData;
      else if (Size == SZ_HALF)
         LoadData = {{16{~Unsigned & halfVal[15]}}, halfVal};
      else
         LoadData = {{24{~Unsigned & byteVal[7]}}, byteVal};

      // Upper bits of WData beyond the access size are dropped by the mask.
      MergeData = (ReadData & ~mask) | ((WData << laneShift(Size, Offset)) & mask);
   end

endmodule

// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: sole master of the word-wide data memory for the core's
// memory stage. One request in flight; sub-word stores are read-modify-write.
//   Clk, Rst_n          clock, asynchronous active-low reset
//   lsu (slave modport) request/response valid/ready handshake
//   MemWrite, MemRead   one-cycle memory strobes, never together
//   Adress              word index (ReqAddr[31:2] modulo MemSize)
//   WriteData           store word to memory
//   ReadData            memory read data, valid the cycle after MemRead
// Build option: LSU_MISALIGN_TRAP_EN - misaligned half/word requests return
// RespError=1 without touching memory; otherwise low address bits are ignored.
`timescale 1ns/1ps
module mips_load_store_unit
   import mips_lsu_pkg::*;
#(
   parameter int unsigned MemSize = 4096
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   mips_load_store_unit_if.slave  lsu,
   output logic                   MemWrite,
   output logic                   MemRead,
   output logic [31:0]            Adress,
   output logic [31:0]            WriteData,
   input  logic [31:0]            ReadData
);

   localparam logic [29:0] IdxMask = 30'(MemSize - 1);

   lsu_state_t  state;
   logic        reqWrite;
   lsu_size_t   reqSize;
   logic        reqUnsigned;
   logic [1:0]  reqOffset;
   logic [31:0] reqWData;

   logic [31:0] loadData;
   logic [31:0] mergeData;
   logic        trapReq;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trapReq = isMisaligned(lsu.ReqSize, lsu.ReqAddr[1:0]);
`else
   assign trapReq = 1'b0;
`endif

   mips_lsu_lane_fmt uLaneFmt (
      .ReadData  (ReadData),
      .WData     (reqWData),
      .Offset    (reqOffset),
      .Size      (reqSize),
      .Unsigned  (reqUnsigned),
      .LoadData  (loadData),
      .MergeData (mergeData)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state         <= IDLE;
         reqWrite      <= 1'b0;
         reqSize       <= SZ_BYTE;
         reqUnsigned   <= 1'b0;
         reqOffset     <= '0;
         reqWData      <= '0;
         lsu.ReqReady  <= 1'b0;
         lsu.RespValid <= 1'b0;
         lsu.RespData  <= '0;
         lsu.RespError <= 1'b0;
         MemWrite      <= 1'b0;
         MemRead       <= 1'b0;
         Adress        <= '0;
         WriteData     <= '0;
      end else begin
         case (state)
            IDLE: begin
               lsu.ReqReady <= 1'b1;
               if (lsu.ReqValid && lsu.ReqReady) begin
                  lsu.ReqReady  <= 1'b0;
                  reqWrite      <= lsu.ReqWrite;
                  reqSize       <= lsu.ReqSize;
                  reqUnsigned   <= lsu.ReqUnsigned;
                  reqOffset     <= lsu.ReqAddr[1:0];
                  reqWData      <= lsu.ReqWData;
                  Adress        <= {2'b00, lsu.ReqAddr[31:2] & IdxMask};
                  lsu.RespData  <= '0;
                  lsu.RespError <= 1'b0;
                  if (trapReq) begin
                     lsu.RespValid <= 1'b1;
                     lsu.RespError <= 1'b1;
                     state         <= RESP;
                  end else if (lsu.ReqWrite && isWordSize(lsu.ReqSize)) begin
                     MemWrite  <= 1'b1;
                     WriteData <= lsu.ReqWData;
                     state     <= WR_ISSUE;
                  end else begin
                     MemRead <= 1'b1;
                     state   <= RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               MemRead <= 1'b0;
               state   <= RD_DATA;
            end
            RD_DATA: begin
               // ReadData is valid here: either finish the load or merge the store lane.
               if (reqWrite) begin
                  MemWrite  <= 1'b1;
                  WriteData <= mergeData;
                  state     <= WR_ISSUE;
               end else begin
                  lsu.RespValid <= 1'b1;
                  lsu.RespData  <= loadData;
                  state         <= RESP;
               end
            end
            WR_ISSUE: begin
               MemWrite      <= 1'b0;
               lsu.RespValid <= 1'b1;
               lsu.RespData  <= '0;
               state         <= RESP;
            end
            RESP: begin
               if (lsu.RespReady) begin
                  lsu.RespValid <= 1'b0;
                  lsu.ReqReady  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_load_store_unit.sv
`timescale 1ns/1ps
module tb_mips_load_store_unit;
   import mips_lsu_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        MemWrite, MemRead;
   logic [31:0] Adress, WriteData;
   logic [31:0] ReadData = '0;
   logic [31:0] mem [0:4095];

   int compared = 0;
   int mismatched = 0;

   mips_load_store_unit_if lsu ();

   mips_load_store_unit #(.MemSize(4096)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .lsu       (lsu),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .Adress    (Adress),
      .WriteData (WriteData),
      .ReadData  (ReadData)
   );

   always #5 Clk = ~Clk;

   // Word-wide data memory with registered read data.
   always @(posedge Clk) begin
      if (MemWrite) mem[Adress[11:0]] <= WriteData;
      if (MemRead)  ReadData <= mem[Adress[11:0]];
   end

   typedef struct {
      logic        wr;
      lsu_size_t   sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic        expErr;
      logic [31:0] expAdr;
      int          lat;
      int          reads;
      int          writes;
      int          hold;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(input logic wr, input lsu_size_t sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr,
                               input logic [31:0] expAdr, input int lat, input int reads,
                               input int writes, input int hold);
      vec_t v;
      v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.expData = expData; v.expErr = expErr; v.expAdr = expAdr; v.lat = lat;
      v.reads = reads; v.writes = writes; v.hold = hold;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic waitReqReady(input string name);
      int n = 0;
      while (!lsu.ReqReady && n < 20) begin
         @(negedge Clk);
         n++;
      end
      check(name, 32'(lsu.ReqReady), 32'd1);
   endtask

   task automatic runVec(input int idx, input vec_t v);
      int          reads = 0, writes = 0, both = 0, first = 0, adrBad = 0;
      logic        seenAcc = 1'b0;
      logic [31:0] adr = '0, data = '0;
      logic        err = 1'b0;
      string       p;
      p = $sformatf("v%0d", idx);
      waitReqReady({p, ".reqready"});
      lsu.ReqValid    = 1'b1;
      lsu.ReqWrite    = v.wr;
      lsu.ReqSize     = v.sz;
      lsu.ReqUnsigned = v.uns;
      lsu.ReqAddr     = v.addr;
      lsu.ReqWData    = v.wdata;
      @(posedge Clk);
      #1 lsu.ReqValid = 1'b0;
      for (int k = 1; k <= 20 && first == 0; k++) begin
         @(negedge Clk);
         if (MemRead && MemWrite) both++;
         if (MemRead || MemWrite) begin
            if (seenAcc && Adress != adr) adrBad++;
            seenAcc = 1'b1;
            adr = Adress;
         end
         if (MemRead)  reads++;
         if (MemWrite) writes++;
         if (lsu.RespValid) begin
            first = k;
            data  = lsu.RespData;
            err   = lsu.RespError;
         end
      end
      check({p, ".latency"}, 32'(first), 32'(v.lat));
      check({p, ".data"}, data, v.expData);
      check({p, ".error"}, 32'(err), 32'(v.expErr));
      check({p, ".reads"}, 32'(reads), 32'(v.reads));
      check({p, ".writes"}, 32'(writes), 32'(v.writes));
      check({p, ".rd_wr_overlap"}, 32'(both), 32'd0);
      check({p, ".adress_stable"}, 32'(adrBad), 32'd0);
      if (v.reads + v.writes > 0) check({p, ".adress"}, adr, v.expAdr);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge Clk);
         check({p, ".hold_valid"}, 32'(lsu.RespValid), 32'd1);
         check({p, ".hold_data"}, lsu.RespData, data);
         check({p, ".hold_reqready"}, 32'(lsu.ReqReady), 32'd0);
      end
      lsu.RespReady = 1'b1;
      @(negedge Clk);
      lsu.RespReady = 1'b0;
      check({p, ".resp_dropped"}, 32'(lsu.RespValid), 32'd0);
      check({p, ".reqready_after"}, 32'(lsu.ReqReady), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      lsu.ReqValid = 1'b0; lsu.ReqWrite = 1'b0; lsu.ReqSize = SZ_BYTE;
      lsu.ReqUnsigned = 1'b0; lsu.ReqAddr = '0; lsu.ReqWData = '0; lsu.RespReady = 1'b0;

      //          wr  size     uns  addr           wdata          expData        err  adr        lat rd wr hold
      vecs.push_back(mk(1, SZ_WORD, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'd4,    2, 0, 1, 0));
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(0, SZ_BYTE, 0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(0, SZ_BYTE, 1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(0, SZ_HALF, 0, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(0, SZ_HALF, 1, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(1, SZ_BYTE, 0, 32'h0000_0011, 32'h0000_0055, 32'h0000_0000, 0, 32'd4,    4, 1, 1, 0));
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(1, SZ_BYTE, 0, 32'h0000_0012, 32'hFFFF_FF77, 32'h0000_0000, 0, 32'd4,    4, 1, 1, 0));
      vecs.push_back(mk(0, 2'b11,   0, 32'h0000_0010, 32'h0,         32'hDE77_55EF, 0, 32'd4,    3, 1, 0, 0));
      vecs.push_back(mk(1, SZ_WORD, 0, 32'h0000_4000, 32'h1122_3344, 32'h0000_0000, 0, 32'd0,    2, 0, 1, 0));
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_4000, 32'h0,         32'h1122_3344, 0, 32'd0,    3, 1, 0, 5));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1, 32'd0,    1, 0, 0, 0));
`else
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_0002, 32'h0,         32'h1122_3344, 0, 32'd0,    3, 1, 0, 0));
`endif
      vecs.push_back(mk(1, SZ_HALF, 0, 32'h0000_0016, 32'h5555_ABCD, 32'h0000_0000, 0, 32'd5,    4, 1, 1, 0));
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_0014, 32'h0,         32'hABCD_0000, 0, 32'd5,    3, 1, 0, 0));
      vecs.push_back(mk(0, SZ_HALF, 0, 32'h0000_0016, 32'h0,         32'hFFFF_ABCD, 0, 32'd5,    3, 1, 0, 0));
      vecs.push_back(mk(0, SZ_WORD, 0, 32'h0000_3FFC, 32'h0,         32'h0000_0000, 0, 32'd4095, 3, 1, 0, 0));
      vecs.push_back(mk(1, SZ_WORD, 0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 0, 32'd8,    2, 0, 1, 0));

      // Reset state
      repeat (2) @(negedge Clk);
      check("reset.reqready", 32'(lsu.ReqReady), 32'd0);
      check("reset.respvalid", 32'(lsu.RespValid), 32'd0);
      check("reset.respdata", lsu.RespData, 32'd0);
      check("reset.resperror", 32'(lsu.RespError), 32'd0);
      check("reset.strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      check("reset.adress", Adress, 32'd0);
      check("reset.writedata", WriteData, 32'd0);
      Rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) runVec(i, vecs[i]);

      // Reset asserted while the sub-word store is in its write cycle.
      waitReqReady("rst.reqready_before");
      lsu.ReqValid = 1'b1; lsu.ReqWrite = 1'b1; lsu.ReqSize = SZ_HALF;
      lsu.ReqUnsigned = 1'b0; lsu.ReqAddr = 32'h0000_0020; lsu.ReqWData = 32'h0000_1234;
      @(posedge Clk);
      #1 lsu.ReqValid = 1'b0;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!MemWrite && n < 10);
      check("rst.write_cycle", 32'(n), 32'd3);
      Rst_n = 1'b0;
      #1;
      check("rst.memwrite_drop", 32'(MemWrite), 32'd0);
      check("rst.memread_drop", 32'(MemRead), 32'd0);
      @(negedge Clk);
      check("rst.word8_kept", mem[8], 32'hCAFE_F00D);
      Rst_n = 1'b1;
      n = 0;
      while (!lsu.ReqReady && n < 3) begin
         @(negedge Clk);
         n++;
      end
      check("rst.reqready_after", 32'(lsu.ReqReady), 32'd1);
      check("rst.no_resp", 32'(lsu.RespValid), 32'd0);
      runVec(100, mk(0, SZ_WORD, 0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 32'd8, 3, 1, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
